// File: rtl/stress_load_sequencer_if.sv
// Control/status bundle between the stress load sequencer and its host.
// Carries the raw button, stop request, lane enables and status flags.
interface stress_load_sequencer_if #(
    parameter int LANES = 8
);
    localparam int AW = $clog2(LANES + 1);

    logic             start_n;
    logic             stop;
    logic [LANES-1:0] lane_en;
    logic [AW-1:0]    active_lanes;
    logic             busy;
    logic             done;
    logic             led;

    modport master (
        output start_n, stop,
        input  lane_en, active_lanes, busy, done, led
    );

    modport slave (
        input  start_n, stop,
        output lane_en, active_lanes, busy, done, led
    );
endinterface

// File: rtl/stress_load_sequencer.sv
// Debounced push-button ramp sequencer for the toggle-load stress array.
// Optional STRESS_LED_STATUS_EN: led blinks per step while ramping, solid in HOLD.
module stress_load_sequencer #(
    parameter int LANES           = 8,
    parameter int DWELL_CYCLES    = 6000,
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic                   clk,
    input  logic                   reset,
    stress_load_sequencer_if.slave bus
);
    localparam int AW = $clog2(LANES + 1);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [AW-1:0] FULL       = AW'(LANES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DOWN = 2'd3;

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             press;
    logic [BW-1:0]    deb_cnt;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [AW-1:0]    act;
    logic [AW-1:0]    act_nx;
    logic [DW-1:0]    dwell;
    logic [DW-1:0]    dwell_nx;
    logic [LANES-1:0] lane_q;
    logic [LANES-1:0] lane_nx;
    logic             busy_q;
    logic             done_q;
    logic             done_nx;
    logic             step;

    // Synchronize the raw button, debounce it and flag each new press.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            deb     <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync1 <= bus.start_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
                press   <= deb;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Ramp state machine: next state, lane count and dwell timer.
    always_comb begin
        state_nx = state;
        act_nx   = act;
        dwell_nx = dwell;
        done_nx  = 1'b0;
        step     = (dwell == DWELL_LAST);
        case (state)
            S_IDLE: begin
                dwell_nx = '0;
                if (press && !bus.stop) begin
                    act_nx   = AW'(1);
                    state_nx = (LANES == 1) ? S_HOLD : S_UP;
                end
            end
            S_UP: begin
                if (bus.stop || press) begin
                    state_nx = S_DOWN;
                    dwell_nx = '0;
                end else if (step) begin
                    dwell_nx = '0;
                    act_nx   = act + 1'b1;
                    if (act_nx == FULL) begin
                        state_nx = S_HOLD;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
            S_HOLD: begin
                dwell_nx = '0;
                if (bus.stop || press) begin
                    state_nx = S_DOWN;
                end
            end
            default: begin
                if (step) begin
                    dwell_nx = '0;
                    act_nx   = act - 1'b1;
                    if (act_nx == '0) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end
        endcase
    end

    // Thermometer mask for the upcoming lane count.
    always_comb begin
        lane_nx = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_nx[i] = (i < int'(act_nx));
        end
    end

    // Register state and all status outputs on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            act    <= '0;
            dwell  <= '0;
            lane_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            act    <= act_nx;
            dwell  <= dwell_nx;
            lane_q <= lane_nx;
            busy_q <= (state_nx != S_IDLE);
            done_q <= done_nx;
        end
    end

    assign bus.lane_en      = lane_q;
    assign bus.active_lanes = act;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

`ifdef STRESS_LED_STATUS_EN
    logic led_q;
    logic ramp_step;

    assign ramp_step = ((state == S_UP) || (state == S_DOWN))
                    && (act_nx != act);

    // Blink on every ramp step, solid while holding, dark when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= 1'b0;
        end else if (state_nx == S_IDLE) begin
            led_q <= 1'b0;
        end else if (state_nx == S_HOLD) begin
            led_q <= 1'b1;
        end else if (ramp_step) begin
            led_q <= ~led_q;
        end
    end

    assign bus.led = led_q;
`else
    assign bus.led = busy_q;
`endif
endmodule

// File: tb/tb_stress_load_sequencer.sv
// Self-checking bench for stress_load_sequencer (LANES=4, DWELL=3, DEBOUNCE=2).
// Directed scenarios plus randomized button/stop traffic against a level model.
module tb_stress_load_sequencer;
    localparam int LANES = 4;
    localparam int DWELL = 3;
    localparam int DEB   = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    stress_load_sequencer_if #(.LANES(LANES)) bus ();

    stress_load_sequencer #(
        .LANES           (LANES),
        .DWELL_CYCLES    (DWELL),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [9:0] obs;
    assign obs = {bus.lane_en, bus.active_lanes, bus.busy, bus.done, bus.led};

    // Expected output vector for a lane level, busy flag and done flag.
    function automatic logic [9:0] exp_vec(input int lvl, input bit b, input bit d);
        logic [3:0] m;
        m = 4'((1 << lvl) - 1);
        return {m, 3'(lvl), b, d, b};
    endfunction

    // Behavioural model: raw button delayed 2 cycles, run-length debounce,
    // and a lane level that moves one step per DWELL cycles.
    int m_s1, m_s2, m_deb, m_run, m_press;
    int m_phase, m_level, m_age, m_done;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = 1; m_s2 = 1; m_deb = 1; m_run = 0; m_press = 0;
            m_phase = 0; m_level = 0; m_age = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                0: if (m_press != 0 && !bus.stop) begin
                    m_level = 1;
                    m_age   = 0;
                    m_phase = (LANES == 1) ? 2 : 1;
                end
                1: if (bus.stop || m_press != 0) begin
                    m_phase = 3;
                    m_age   = 0;
                end else begin
                    m_age++;
                    if (m_age == DWELL) begin
                        m_age = 0;
                        m_level++;
                        if (m_level == LANES) m_phase = 2;
                    end
                end
                2: if (bus.stop || m_press != 0) begin
                    m_phase = 3;
                    m_age   = 0;
                end
                default: begin
                    m_age++;
                    if (m_age == DWELL) begin
                        m_age = 0;
                        m_level--;
                        if (m_level == 0) begin
                            m_phase = 0;
                            m_done  = 1;
                        end
                    end
                end
            endcase
            m_press = 0;
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb   = m_s2;
                    m_run   = 0;
                    m_press = (m_s2 == 0) ? 1 : 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(bus.start_n);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.start_n = 1'b1;
        bus.stop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Wait (bounded) until active_lanes reaches lvl; timeout is a failure.
    task automatic wait_level(input int lvl, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (int'(bus.active_lanes) == lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s wait_level got=%0d exp=%0d", tag, bus.active_lanes, lvl);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_n = 1'b0;
        bus.stop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (obs !== exp_vec(0, 0, 0)) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", obs, exp_vec(0, 0, 0));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs !== exp_vec(0, 0, 0)) begin
            failures++;
            $display("FAIL reset_latency_early got=%b exp=%b", obs, exp_vec(0, 0, 0));
        end
        @(negedge clk);
        checks++;
        if (obs !== exp_vec(1, 1, 0)) begin
            failures++;
            $display("FAIL reset_latency got=%b exp=%b", obs, exp_vec(1, 1, 0));
        end
        do_reset();
    endtask

    task automatic test_glitch();
        bus.start_n = 1'b0;
        @(negedge clk);
        bus.start_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_vec(0, 0, 0)) begin
                failures++;
                $display("FAIL glitch t=%0d got=%b exp=%b", t, obs, exp_vec(0, 0, 0));
            end
        end
    endtask

    task automatic test_ramp_up();
        int lvl;
        bus.start_n = 1'b0;
        wait_level(1, "ramp_up");
        bus.start_n = 1'b1;
        for (int t = 0; t < 60; t++) begin
            lvl = (t < 9) ? 1 + t / 3 : 4;
            checks++;
            if (obs !== exp_vec(lvl, 1, 0)) begin
                failures++;
                $display("FAIL ramp_up t=%0d got=%b exp=%b", t, obs, exp_vec(lvl, 1, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ramp_down(input bool_press);
        int lvl;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        if (bool_press) bus.start_n = 1'b0;
        for (int t = 0; t < 15; t++) begin
            lvl = (t >= 12) ? 0 : 4 - t / 3;
            checks++;
            if (obs !== exp_vec(lvl, t < 12, t == 12)) begin
                failures++;
                $display("FAIL ramp_down t=%0d got=%b exp=%b", t, obs, exp_vec(lvl, t < 12, t == 12));
            end
            @(negedge clk);
        end
        bus.start_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_abort();
        int lvl;
        int dones;
        int maxl;
        dones = 0;
        maxl = 0;
        bus.start_n = 1'b0;
        wait_level(1, "abort");
        bus.start_n = 1'b1;
        wait_level(2, "abort");
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        for (int t = 0; t < 11; t++) begin
            lvl = (t < 3) ? 2 : (t < 6) ? 1 : 0;
            if (bus.done) dones++;
            if (int'(bus.active_lanes) > maxl) maxl = int'(bus.active_lanes);
            checks++;
            if (obs !== exp_vec(lvl, t < 6, t == 6)) begin
                failures++;
                $display("FAIL abort t=%0d got=%b exp=%b", t, obs, exp_vec(lvl, t < 6, t == 6));
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL abort_done_count got=%0d exp=1", dones);
        end
        checks++;
        if (maxl > 2) begin
            failures++;
            $display("FAIL abort_max_level got=%0d exp=2", maxl);
        end
    endtask

    task automatic test_ignored();
        bus.start_n = 1'b0;
        wait_level(1, "ign_down");
        bus.start_n = 1'b1;
        wait_level(4, "ign_down");
        repeat (3) @(negedge clk);
        test_ramp_down(1'b1);
        bus.stop = 1'b1;
        bus.start_n = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (t == 12) bus.start_n = 1'b1;
            if (t == 20) bus.stop = 1'b0;
            checks++;
            if (obs !== exp_vec(0, 0, 0)) begin
                failures++;
                $display("FAIL ign_stop_press t=%0d got=%b exp=%b", t, obs, exp_vec(0, 0, 0));
            end
            @(negedge clk);
        end
        bus.start_n = 1'b0;
        wait_level(1, "ign_reset");
        bus.start_n = 1'b1;
        wait_level(3, "ign_reset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (obs !== exp_vec(0, 0, 0)) begin
                failures++;
                $display("FAIL ign_reset t=%0d got=%b exp=%b", t, obs, exp_vec(0, 0, 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int hold;
        logic [9:0] e;
        hold = 0;
        do_reset();
        for (int t = 0; t < 3000; t++) begin
            e = exp_vec(m_level, m_phase != 0, m_done != 0);
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL random t=%0d got=%b exp=%b", t, obs, e);
            end
            if (hold == 0) begin
                bus.start_n = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            bus.stop = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        bus.stop = 1'b0;
        bus.start_n = 1'b1;
    endtask

    initial begin
        bus.start_n = 1'b1;
        bus.stop = 1'b0;
        do_reset();
        test_reset();
        test_glitch();
        test_ramp_up();
        test_ramp_down(1'b0);
        test_abort();
        repeat (8) @(negedge clk);
        test_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
